btn_event_arbiter: RTL and testbench
====================================

// Module: btn_event_arbiter
// PURPOSE
//  Turns the five debounced push-buttons into a queued stream of press events.
//  Rising edges are arbitrated round-robin, one per cycle, into a small FWFT FIFO, each tagged with a 16-bit switch snapshot.
//  Consumers read the FIFO through a valid/ready handshake.
//  Sits between the board input controller's DBTN outputs and any menu/command sequencer.
// PARAMETERS
//  FIFO_DEPTH  4           event FIFO entries; power of 2, >=2
//  HOLD_CYC    50_000_000  cycles a lone button must be held before first repeat (500 ms @100 MHz)
//  REP_CYC     10_000_000  cycles between subsequent repeats (100 ms @100 MHz)
// PORTS
//  CLK100_I     in   1   100 MHz board clock
//  RSTN_I       in   1   async active-low reset
//  DBTN_I       in   5   debounced buttons, bit 0 C, 1 U, 2 L, 3 R, 4 D; synchronous to CLK100_I
//  SW_I         in   16  switch bus, sampled when an event is pushed
//  EVT_READY_I  in   1   consumer accepts the head event
//  EVT_VALID_O  out  1   FIFO non-empty
//  EVT_CODE_O   out  3   button index of the head event (0..4)
//  EVT_REP_O    out  1   head event is an auto-repeat
//  EVT_SW_O     out  16  SW_I snapshot of the head event
//  FIFO_CNT_O   out  $clog2(FIFO_DEPTH)+1   current occupancy
//  OVF_O        out  1   sticky: an event was coalesced or lost
//  OVF_CLR_I    in   1   synchronous clear of OVF_O
// BEHAVIOUR
//  Reset (async, RSTN_I=0) clears all registers: prev, pend, pend_rep, RR pointer (0), FIFO pointers, timer, OVF_O.
//  All outputs are 0 in reset.
//  Edge detect: rise = DBTN_I & ~prev; prev <= DBTN_I.
//  At edge k: pend[i] <= 1 and pend_rep[i] <= 0 for each rise[i].
//  Coalescing: if rise[i] arrives while pend[i] is already 1 and is not being granted that cycle, OVF_O <= 1 and the event merges; no second entry is made.
//  Arbiter (comb):
//   - grant = first set pend bit, searching from RR pointer upward with wrap 4->0.
//   - Push happens when pend != 0 and (count < FIFO_DEPTH, or a pop occurs the same cycle).
//   - On push: write {idx, pend_rep[idx], SW_I}, clear pend[idx], set RR pointer <= idx+1 (4 wraps to 0).
//   - At most one push per cycle.
//  Latency: DBTN_I rise sampled at edge k -> pushed at edge k+1 -> EVT_VALID_O=1 after edge k+1.
//  FIFO is first-word-fall-through: EVT_* show the head entry whenever EVT_VALID_O=1.
//   - Pop when EVT_VALID_O & EVT_READY_I.
//   - EVT_READY_I with the FIFO empty is ignored.
//   - Full FIFO: pend bits are held, not dropped; they push as space frees.
//   - Push and pop in the same cycle: count is unchanged, and this is legal when full.
//  Pointers wrap modulo FIFO_DEPTH. FIFO_CNT_O = wr-rd occupancy, range 0..FIFO_DEPTH.
//  OVF_CLR_I: clear wins over a same-cycle set.
//  EVT_CODE_O/EVT_REP_O/EVT_SW_O are don't-care while EVT_VALID_O=0; the bench must not check them then.
// CONFIGURATION
//  BTN_REPEAT_EN defined:
//   - A 32-bit hold timer runs while exactly one DBTN_I bit is high.
//   - The timer resets to 0 whenever DBTN_I != prev, or when zero or multiple bits are high.
//   - When the timer reaches HOLD_CYC-1: set pend[i] and pend_rep[i]; the timer reloads with phase REP_CYC.
//   - Thereafter a repeat fires every REP_CYC cycles until release.
//   - A repeat on an already-pending button sets OVF_O (same coalescing rule).
//  BTN_REPEAT_EN undefined:
//   - No timer logic is generated.
//   - pend_rep stays 0 and EVT_REP_O is constant 0.
//   - Only rising edges create events.
// TESTING (bench: FIFO_DEPTH=4, HOLD_CYC=20, REP_CYC=5)
//  1 Reset: RSTN_I low mid-stream with 3 entries queued -> all outputs 0 immediately; after release FIFO_CNT_O=0.
//  2 Single press: SW_I=16'hA5A5, DBTN_I=5'b00100 at edge k, READY=1 -> VALID=1 after k+1, CODE=2, REP=0, SW=A5A5, one entry only.
//  3 Simultaneous: DBTN_I 0->5'b11111 in one cycle, READY=0, RR=0 -> FIFO holds 0,1,2,3; pend[4] waits.
//     Then one pop -> code 4 pushed the same cycle; FIFO_CNT_O stays 4; OVF_O=0.
//  4 Round-robin: after granting idx 3, press C and D together -> D (4) queued before C (0).
//  5 Overflow: FIFO full, READY=0, press U, release, press U again -> OVF_O=1 and only one U ever delivered.
//     OVF_CLR_I pulse -> OVF_O=0.
//  6 Repeat (BTN_REPEAT_EN): hold R for 40 cycles, READY=1 -> events CODE=3 with REP=0, then REP=1 at hold cycles 20, 25, 30, 35.
//     Also press L during the hold -> repeats stop.
//     Without the macro, the same stimulus gives a single event.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
// Turns five debounced push-buttons into a queued stream of press events.
// Rising edges are arbitrated round-robin, one per cycle, into a small
// first-word-fall-through FIFO. Each entry is tagged with a 16-bit switch
// snapshot. A consumer drains the FIFO through a valid/ready handshake.
// Optional feature macro: BTN_REPEAT_EN
//   defined   -> a lone held button generates auto-repeat events
//   undefined -> only rising edges create events; EVT_REP_O is always 0
module btn_event_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REP_CYC    = 10_000_000
) (
    input  logic                          CLK100_I,
    input  logic                          RSTN_I,
    input  logic [4:0]                    DBTN_I,
    input  logic [15:0]                   SW_I,
    input  logic                          EVT_READY_I,
    output logic                          EVT_VALID_O,
    output logic [2:0]                    EVT_CODE_O,
    output logic                          EVT_REP_O,
    output logic [15:0]                   EVT_SW_O,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT_O,
    output logic                          OVF_O,
    input  logic                          OVF_CLR_I
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Reject configurations the pointer arithmetic and timers cannot handle.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (HOLD_CYC < 1) || (REP_CYC < 1)) begin : g_bad_cfg
        $error("btn_event_arbiter: unsupported parameter set");
    end

    // Entry layout: {code[2:0], rep, sw[15:0]}
    logic [19:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic [4:0]    r_prev;
    logic [4:0]    r_pend;
    logic [4:0]    r_pend_rep;
    logic [2:0]    r_rr;
    logic          r_ovf;

    logic [4:0]    w_rise;
    logic [4:0]    w_rep_set;
    logic [4:0]    w_set;
    logic [2:0]    w_gnt_idx;
    logic          w_gnt_vld;
    logic [4:0]    w_gnt_oh;
    logic          w_gnt_rep;
    logic          w_pop;
    logic          w_push;
    logic [4:0]    w_clr;
    logic          w_coal;

`ifdef BTN_REPEAT_EN
    logic [31:0]   r_timer;
    logic          r_rep_ph;
    logic          w_single;
    logic          w_stable;
    logic [31:0]   w_limit;
    logic          w_fire;

    // Hold detection: a lone, unchanged button counts toward its next repeat.
    always_comb begin
        w_single  = (DBTN_I != 5'd0) && ((DBTN_I & (DBTN_I - 5'd1)) == 5'd0);
        w_stable  = (DBTN_I == r_prev);
        w_limit   = r_rep_ph ? 32'(REP_CYC - 1) : 32'(HOLD_CYC - 1);
        w_fire    = w_single && w_stable && (r_timer == w_limit);
        w_rep_set = w_fire ? DBTN_I : 5'd0;
    end

    // Hold timer: first period is HOLD_CYC, later periods REP_CYC.
    always_ff @(posedge CLK100_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_timer  <= 32'd0;
            r_rep_ph <= 1'b0;
        end else if (!(w_single && w_stable)) begin
            r_timer  <= 32'd0;
            r_rep_ph <= 1'b0;
        end else if (w_fire) begin
            r_timer  <= 32'd0;
            r_rep_ph <= 1'b1;
        end else begin
            r_timer  <= r_timer + 32'd1;
        end
    end
`else
    // No repeat source: only rising edges create events.
    assign w_rep_set = 5'd0;
`endif

    // Round-robin grant among pending buttons, starting at the RR pointer.
    always_comb begin
        w_gnt_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            w_gnt_idx = r_pend[(int'(r_rr) + k) % 5] ? 3'((int'(r_rr) + k) % 5) : w_gnt_idx;
        end
        w_gnt_vld = (r_pend != 5'd0);
        w_gnt_oh  = w_gnt_vld ? (5'd1 << w_gnt_idx) : 5'd0;
        w_gnt_rep = |(w_gnt_oh & r_pend_rep);
    end

    // Push/pop decisions and pending-set bookkeeping.
    always_comb begin
        w_rise = DBTN_I & ~r_prev;
        w_set  = w_rise | w_rep_set;
        w_pop  = (r_cnt != '0) && EVT_READY_I;
        w_push = w_gnt_vld && ((r_cnt < DEPTH_C) || w_pop);
        w_clr  = w_push ? w_gnt_oh : 5'd0;
        w_coal = |(w_set & r_pend & ~w_clr);
    end

    // Edge history, pending sets, RR pointer and sticky overflow flag.
    always_ff @(posedge CLK100_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_prev     <= 5'd0;
            r_pend     <= 5'd0;
            r_pend_rep <= 5'd0;
            r_rr       <= 3'd0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev     <= DBTN_I;
            r_pend     <= (r_pend & ~w_clr) | w_set;
            r_pend_rep <= (r_pend_rep & ~w_clr & ~w_rise) | w_rep_set;
            if (w_push) begin
                r_rr <= (w_gnt_idx == 3'd4) ? 3'd0 : (w_gnt_idx + 3'd1);
            end
            if (OVF_CLR_I) begin
                r_ovf <= 1'b0;
            end else if (w_coal) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK100_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 20'd0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {w_gnt_idx, w_gnt_rep, SW_I};
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign EVT_VALID_O = (r_cnt != '0);
    assign EVT_CODE_O  = r_mem[r_rd][19:17];
    assign EVT_REP_O   = r_mem[r_rd][16];
    assign EVT_SW_O    = r_mem[r_rd][15:0];
    assign FIFO_CNT_O  = r_cnt;
    assign OVF_O       = r_ovf;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios plus randomized button
// traffic, checked by a scoreboard fed from a behavioural reference model.
module tb_btn_event_arbiter;

    localparam int DEPTH = 4;
    localparam int HOLD  = 20;
    localparam int REP   = 5;

    logic        clk;
    logic        rstn;
    logic [4:0]  dbtn;
    logic [15:0] sw_in;
    logic        rdy;
    logic        ovf_clr;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic        evt_rep;
    logic [15:0] evt_sw;
    logic [2:0]  fifo_cnt;
    logic        ovf;

    btn_event_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYC   (HOLD),
        .REP_CYC    (REP)
    ) dut (
        .CLK100_I    (clk),
        .RSTN_I      (rstn),
        .DBTN_I      (dbtn),
        .SW_I        (sw_in),
        .EVT_READY_I (rdy),
        .EVT_VALID_O (evt_valid),
        .EVT_CODE_O  (evt_code),
        .EVT_REP_O   (evt_rep),
        .EVT_SW_O    (evt_sw),
        .FIFO_CNT_O  (fifo_cnt),
        .OVF_O       (ovf),
        .OVF_CLR_I   (ovf_clr)
    );

    typedef struct {
        int          code;
        int          rep;
        logic [15:0] sw;
    } ev_t;

    ev_t  sb_q[$];
    ev_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   n_rep_pop = 0;
    int   n_u_pop = 0;

    // reference model state
    bit         m_pend[5];
    bit         m_prep[5];
    logic [4:0] m_prev;
    int         m_rr;
    int         m_cnt;
    bit         m_ovf;
`ifdef BTN_REPEAT_EN
    int         m_hold;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        sb_q.delete();
        for (int i = 0; i < 5; i++) begin
            m_pend[i] = 1'b0;
            m_prep[i] = 1'b0;
        end
        m_prev = 5'd0;
        m_rr   = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
`ifdef BTN_REPEAT_EN
        m_hold = 0;
`endif
    endtask

    // One clock of the reference: pending sets, RR search, FIFO occupancy.
    task automatic model_step();
        int g;
        int fire;
        bit pop;
        bit rise;
        if (!rstn) begin
            model_clear();
            return;
        end
        pop = (m_cnt > 0) && rdy;
        g = -1;
        if (m_cnt < DEPTH || pop) begin
            for (int k = 0; k < 5; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % 5]) g = (m_rr + k) % 5;
            end
        end
        if (g >= 0) begin
            sb_q.push_back('{code: g, rep: int'(m_prep[g]), sw: sw_in});
            m_pend[g] = 1'b0;
            m_prep[g] = 1'b0;
            m_rr = (g + 1) % 5;
            m_cnt++;
        end
        if (pop) m_cnt--;
        fire = -1;
`ifdef BTN_REPEAT_EN
        if (dbtn != m_prev || $countones(dbtn) != 1) m_hold = 0;
        else m_hold++;
        if (m_hold >= HOLD && ((m_hold - HOLD) % REP) == 0) begin
            for (int i = 0; i < 5; i++) if (dbtn[i]) fire = i;
        end
`endif
        for (int i = 0; i < 5; i++) begin
            rise = dbtn[i] && !m_prev[i];
            if (rise || fire == i) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1;
                m_prep[i] = rise ? 1'b0 : 1'b1;
            end
        end
        if (ovf_clr) m_ovf = 1'b0;
        m_prev = dbtn;
    endtask

    // Reference model advances on every active edge.
    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare occupancy/flags each cycle and the head on every pop.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("valid", 32'(evt_valid), 32'(sb_q.size() != 0));
                chk("count", 32'(fifo_cnt), sb_q.size());
                chk("ovf", 32'(ovf), 32'(m_ovf));
                if (evt_valid && rdy) begin
                    n_pop++;
                    if (evt_rep) n_rep_pop++;
                    if (evt_code == 3'd1) n_u_pop++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_empty: got code %0d expected no event", evt_code);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("code", 32'(evt_code), mon_e.code);
                        chk("rep", 32'(evt_rep), mon_e.rep);
                        chk("sw", 32'(evt_sw), 32'(mon_e.sw));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        dbtn = 5'd0;
        rdy  = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_rep", 32'(evt_rep), 32'd0);
        chk("rst_sw", 32'(evt_sw), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        model_clear();
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("rst_cnt_after", 32'(fifo_cnt), 32'd0);
    endtask

    int p0, r0, u0, dur, sel;
    logic [4:0] pat;

    initial begin
        rstn = 1'b0; dbtn = 5'd0; sw_in = 16'd0; rdy = 1'b0; ovf_clr = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // single press with latency check
        rdy = 1'b1; sw_in = 16'hA5A5; dbtn = 5'b00100;
        tick(1);
        chk("s2_not_yet", 32'(evt_valid), 32'd0);
        tick(1);
        chk("s2_valid", 32'(evt_valid), 32'd1);
        chk("s2_code", 32'(evt_code), 32'd2);
        chk("s2_rep", 32'(evt_rep), 32'd0);
        chk("s2_sw", 32'(evt_sw), 32'hA5A5);
        dbtn = 5'd0;
        tick(1);
        chk("s2_one_entry", 32'(evt_valid), 32'd0);

        // reset mid-stream with three entries queued
        rdy = 1'b0; dbtn = 5'b00111; sw_in = 16'h1234;
        tick(5);
        chk("s1_queued", 32'(fifo_cnt), 32'd3);
        do_reset();

        // simultaneous press of all five buttons
        rdy = 1'b0; dbtn = 5'b11111; sw_in = 16'h0F0F;
        tick(6);
        chk("s3_full", 32'(fifo_cnt), 32'd4);
        chk("s3_head", 32'(evt_code), 32'd0);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("s3_cnt_same", 32'(fifo_cnt), 32'd4);
        chk("s3_head2", 32'(evt_code), 32'd1);
        chk("s3_ovf", 32'(ovf), 32'd0);
        dbtn = 5'd0; rdy = 1'b1;
        tick(6);
        chk("s3_drained", 32'(evt_valid), 32'd0);

        // round-robin continues after index 3
        dbtn = 5'b01000;
        tick(2);
        dbtn = 5'd0;
        tick(4);
        chk("s4_idle", 32'(evt_valid), 32'd0);
        rdy = 1'b0; dbtn = 5'b10001;
        tick(4);
        chk("s4_cnt", 32'(fifo_cnt), 32'd2);
        chk("s4_first_d", 32'(evt_code), 32'd4);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("s4_then_c", 32'(evt_code), 32'd0);
        chk("s4_cnt1", 32'(fifo_cnt), 32'd1);

        // overflow by re-pressing U while the FIFO is full
        dbtn = 5'd0;
        tick(2);
        dbtn = 5'b01101;
        tick(5);
        chk("s5_full", 32'(fifo_cnt), 32'd4);
        dbtn = 5'b01111;
        tick(2);
        dbtn = 5'b01101;
        tick(2);
        dbtn = 5'b01111;
        tick(2);
        chk("s5_ovf_set", 32'(ovf), 32'd1);
        chk("s5_still_full", 32'(fifo_cnt), 32'd4);
        u0 = n_u_pop;
        dbtn = 5'd0; rdy = 1'b1;
        tick(10);
        chk("s5_drained", 32'(evt_valid), 32'd0);
        chk("s5_u_once", n_u_pop - u0, 32'd1);
        chk("s5_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("s5_ovf_clr", 32'(ovf), 32'd0);

        // hold R for 40 cycles
        p0 = n_pop; r0 = n_rep_pop;
        dbtn = 5'b01000;
        tick(40);
        dbtn = 5'd0;
        tick(6);
`ifdef BTN_REPEAT_EN
        chk("s6_events", n_pop - p0, 32'd5);
        chk("s6_repeats", n_rep_pop - r0, 32'd4);
`else
        chk("s6_events", n_pop - p0, 32'd1);
        chk("s6_repeats", n_rep_pop - r0, 32'd0);
`endif

        // hold R, then add L: repeats stop
        p0 = n_pop; r0 = n_rep_pop;
        dbtn = 5'b01000;
        tick(22);
        dbtn = 5'b01100;
        tick(30);
        dbtn = 5'd0;
        tick(6);
`ifdef BTN_REPEAT_EN
        chk("s6b_events", n_pop - p0, 32'd3);
        chk("s6b_repeats", n_rep_pop - r0, 32'd1);
`else
        chk("s6b_events", n_pop - p0, 32'd2);
        chk("s6b_repeats", n_rep_pop - r0, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      pat = 5'd1 << $urandom_range(0, 4);
            else if (sel < 8) pat = 5'($urandom_range(0, 31));
            else              pat = 5'd0;
            dur = $urandom_range(1, 30);
            for (int c = 0; c < dur; c++) begin
                dbtn    = pat;
                sw_in   = 16'($urandom);
                rdy     = ($urandom_range(0, 3) != 0);
                ovf_clr = ($urandom_range(0, 15) == 0);
                tick(1);
            end
        end

        dbtn = 5'd0; rdy = 1'b1; ovf_clr = 1'b0;
        tick(12);
        chk("final_empty", 32'(evt_valid), 32'd0);
        chk("final_sb", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
